// File: rtl/deserializer.sv
// rtl/deserializer.sv - packs N_SAMPLES BIT_WIDTH-bit samples into one parallel frame
//
// Purpose:
//   Receive-side counterpart of the serializer. Samples arrive one per
//   val/rdy handshake and are written into slot cnt of a register bank.
//   When the last slot is filled, the bank is presented as a frame on
//   the send interface. The frame is held there until the consumer takes it.
//   Collection and sending never overlap.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   recv_msg  in   [BIT_WIDTH-1:0] incoming sample
//   recv_val  in   recv_msg valid
//   recv_rdy  out  ready for a sample (COLLECT state)
//   send_msg  out  [BIT_WIDTH-1:0] x [N_SAMPLES-1:0]; element i = i-th sample of the frame
//   send_val  out  frame valid (SEND state)
//   send_rdy  in   consumer accepts the frame
//   flush     in   (only with DESERIALIZER_FLUSH_EN) emit a partially filled frame
//
// Optional feature macro: DESERIALIZER_FLUSH_EN

module deserializer #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
   output logic                 send_val,
`ifdef DESERIALIZER_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 send_rdy
);

   localparam int CNT_W = $clog2(N_SAMPLES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_SEND    = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0] regs_q [N_SAMPLES-1:0];
   logic [BIT_WIDTH-1:0] regs_d [N_SAMPLES-1:0];

   // State register and sample bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_COLLECT;
         cnt_q   <= '0;
         for (int i = 0; i < N_SAMPLES; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < N_SAMPLES; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < N_SAMPLES; i++) begin
         regs_d[i] = regs_q[i];
      end

      case (state_q)
         ST_COLLECT: begin
            if (recv_val) begin
               regs_d[cnt_q] = recv_msg;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = ST_SEND;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`ifdef DESERIALIZER_FLUSH_EN
            // A same-cycle sample has already been captured above; flush
            // then closes the frame. An empty flush (nothing held, nothing
            // arriving) is ignored so that no all-zero frame is emitted.
            if (flush && ((cnt_q != '0) || recv_val)) begin
               cnt_d   = '0;
               state_d = ST_SEND;
            end
`endif
         end
         ST_SEND: begin
            if (send_rdy) begin
               state_d = ST_COLLECT;
`ifdef DESERIALIZER_FLUSH_EN
               // Clearing here makes unfilled slots of a flushed frame read 0.
               for (int i = 0; i < N_SAMPLES; i++) begin
                  regs_d[i] = '0;
               end
`endif
            end
         end
         default: begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
         end
      endcase
   end

   // Handshake outputs decode from state only; no input-to-output paths.
   always_comb begin
      recv_rdy = (state_q == ST_COLLECT);
      send_val = (state_q == ST_SEND);
      for (int i = 0; i < N_SAMPLES; i++) begin
         send_msg[i] = regs_q[i];
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - self-checking bench for deserializer

module tb_deserializer;

   localparam int BW = 32;
   localparam int N  = 8;

   logic          clk;
   logic          reset;
   logic [BW-1:0] recv_msg;
   logic          recv_val;
   logic          recv_rdy;
   logic [BW-1:0] send_msg [N-1:0];
   logic          send_val;
   logic          send_rdy;
`ifdef DESERIALIZER_FLUSH_EN
   logic          flush;
`endif

   int n_cmp;
   int n_err;

   deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .recv_msg (recv_msg),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .send_msg (send_msg),
      .send_val (send_val),
`ifdef DESERIALIZER_FLUSH_EN
      .flush    (flush),
`endif
      .send_rdy (send_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_frame(input string name, input logic [BW-1:0] exp [N]);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s slot%0d", name, k), send_msg[k], exp[k]);
      end
   endtask

   // Apply inputs, take one rising edge, land 1 time unit after it.
   task automatic step(input logic v, input logic [BW-1:0] m, input logic sr);
      recv_val = v;
      recv_msg = m;
      send_rdy = sr;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          val;
      logic [BW-1:0] msg;
      logic          srdy;
      logic          exp_rrdy;
      logic          exp_sval;
      logic          chk_frame;
      logic [BW-1:0] base;
   } vec_t;

   vec_t          vecs [N+1];
   logic [BW-1:0] exp_f [N];

   // Reference model state: samples accepted so far and the pending frame.
   logic [BW-1:0] mq [$];
   logic [BW-1:0] m_frame [N];
   logic          m_pending;

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      reset    = 1'b0;
      recv_val = 1'b0;
      recv_msg = '0;
      send_rdy = 1'b0;
`ifdef DESERIALIZER_FLUSH_EN
      flush    = 1'b0;
`endif

      // ---------------- reset then idle ----------------
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("in_reset recv_rdy", BW'(recv_rdy), 1);
      check("in_reset send_val", BW'(send_val), 0);
      reset = 1'b1;
      for (int k = 0; k < N; k++) exp_f[k] = '0;
      check_frame("reset frame", exp_f);
      for (int c = 0; c < 10; c++) step(1'b0, BW'($urandom), 1'b0);
      check("idle recv_rdy", BW'(recv_rdy), 1);
      check("idle send_val", BW'(send_val), 0);
      check_frame("idle frame", exp_f);

      // ---------------- table-driven basic frame ----------------
      for (int i = 0; i < N + 1; i++) begin
         vecs[i].val       = (i < N);
         vecs[i].msg       = (i < N) ? BW'(32'h10 + i) : '0;
         vecs[i].srdy      = 1'b1;
         vecs[i].exp_rrdy  = (i != N - 1);
         vecs[i].exp_sval  = (i == N - 1);
         vecs[i].chk_frame = (i == N - 1);
         vecs[i].base      = BW'(32'h10);
      end
      for (int i = 0; i < N + 1; i++) begin
         step(vecs[i].val, vecs[i].msg, vecs[i].srdy);
         check($sformatf("vec%0d recv_rdy", i), BW'(recv_rdy), BW'(vecs[i].exp_rrdy));
         check($sformatf("vec%0d send_val", i), BW'(send_val), BW'(vecs[i].exp_sval));
         if (vecs[i].chk_frame) begin
            for (int k = 0; k < N; k++) exp_f[k] = vecs[i].base + BW'(k);
            check_frame($sformatf("vec%0d frame", i), exp_f);
         end
      end

      // ---------------- backpressure both sides ----------------
      for (int i = 0; i < N; i++) begin
         int gap;
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) step(1'b0, 32'hBAD0, 1'(($urandom) & 1));
         check($sformatf("bp gap%0d recv_rdy", i), BW'(recv_rdy), 1);
         step(1'b1, BW'(32'h40 + i), 1'b0);
      end
      for (int k = 0; k < N; k++) exp_f[k] = BW'(32'h40 + k);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp hold%0d send_val", c), BW'(send_val), 1);
         check($sformatf("bp hold%0d recv_rdy", c), BW'(recv_rdy), 0);
         check_frame($sformatf("bp hold%0d frame", c), exp_f);
         if (c == 2) step(1'b1, 32'hDEAD, 1'b0);
         else        step(1'b0, '0, 1'b0);
      end
      check("bp post_dead send_val", BW'(send_val), 1);
      check_frame("bp post_dead frame", exp_f);
      step(1'b0, '0, 1'b1);
      check("bp release recv_rdy", BW'(recv_rdy), 1);
      check("bp release send_val", BW'(send_val), 0);

      // ---------------- two consecutive frames ----------------
      for (int i = 0; i < N; i++) step(1'b1, BW'(32'h100 + i), 1'b1);
      check("f1 send_val", BW'(send_val), 1);
      for (int k = 0; k < N; k++) exp_f[k] = BW'(32'h100 + k);
      check_frame("f1 frame", exp_f);
      step(1'b0, '0, 1'b1);
      check("f1 one_send_cycle recv_rdy", BW'(recv_rdy), 1);
      for (int i = 0; i < N; i++) step(1'b1, BW'(32'h200 + i), 1'b1);
      check("f2 send_val", BW'(send_val), 1);
      for (int k = 0; k < N; k++) exp_f[k] = BW'(32'h200 + k);
      check_frame("f2 frame", exp_f);
      step(1'b0, '0, 1'b1);

      // ---------------- async reset mid-frame ----------------
      for (int i = 0; i < 3; i++) step(1'b1, BW'(32'h5A0 + i), 1'b0);
      check("pre_rst slot0", send_msg[0], 32'h5A0);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst recv_rdy", BW'(recv_rdy), 1);
      check("async_rst send_val", BW'(send_val), 0);
      for (int k = 0; k < N; k++) exp_f[k] = '0;
      check_frame("async_rst frame", exp_f);
      step(1'b0, '0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < N; i++) step(1'b1, BW'(32'h30 + i), 1'b0);
      check("post_rst send_val", BW'(send_val), 1);
      for (int k = 0; k < N; k++) exp_f[k] = BW'(32'h30 + k);
      check_frame("post_rst frame", exp_f);
      step(1'b0, '0, 1'b1);

`ifdef DESERIALIZER_FLUSH_EN
      // ---------------- flush ----------------
      flush = 1'b1;
      step(1'b0, '0, 1'b0);
      flush = 1'b0;
      check("empty_flush recv_rdy", BW'(recv_rdy), 1);
      step(1'b1, 32'hA, 1'b0);
      step(1'b1, 32'hB, 1'b0);
      flush = 1'b1;
      step(1'b0, '0, 1'b0);
      flush = 1'b0;
      check("flush1 send_val", BW'(send_val), 1);
      for (int k = 0; k < N; k++) exp_f[k] = '0;
      exp_f[0] = 32'hA;
      exp_f[1] = 32'hB;
      check_frame("flush1 frame", exp_f);
      step(1'b0, '0, 1'b1);
      step(1'b1, 32'hA, 1'b0);
      step(1'b1, 32'hB, 1'b0);
      flush = 1'b1;
      step(1'b1, 32'hC, 1'b0);
      flush = 1'b0;
      check("flush2 send_val", BW'(send_val), 1);
      exp_f[2] = 32'hC;
      check_frame("flush2 frame", exp_f);
      step(1'b0, '0, 1'b1);
      check("flush2 release recv_rdy", BW'(recv_rdy), 1);
`endif

      // ---------------- randomized vs reference model ----------------
      mq.delete();
      m_pending = 1'b0;
      for (int k = 0; k < N; k++) m_frame[k] = '0;
      for (int c = 0; c < 600; c++) begin
         logic          v;
         logic          sr;
         logic [BW-1:0] m;
         v  = ($urandom_range(0, 3) != 0);
         sr = ($urandom_range(0, 2) != 0);
         m  = BW'($urandom);
         step(v, m, sr);
         if (m_pending) begin
            if (sr) m_pending = 1'b0;
         end else if (v) begin
            mq.push_back(m);
            if (mq.size() == N) begin
               for (int k = 0; k < N; k++) m_frame[k] = mq[k];
               mq.delete();
               m_pending = 1'b1;
            end
         end
         check($sformatf("rnd%0d recv_rdy", c), BW'(recv_rdy), BW'(!m_pending));
         check($sformatf("rnd%0d send_val", c), BW'(send_val), BW'(m_pending));
         if (m_pending) check_frame($sformatf("rnd%0d frame", c), m_frame);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
